// File: rtl/ysyx_22041752_mul_issue.sv
// Issue/result-capture controller between EXE and the iterative multiplier.
// Latency: product return + 1 cycle; result held until ms_allowin; flush kills in-flight work.
module ysyx_22041752_mul_issue #(
    parameter int DATA_WD = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               es_valid,
    input  logic [2:0]         es_mul_op,
    input  logic               es_mul_w,
    input  logic [DATA_WD-1:0] es_src1,
    input  logic [DATA_WD-1:0] es_src2,
    input  logic               ms_allowin,
    output logic               es_ready_go,
    output logic [DATA_WD-1:0] es_result,
    output logic               mul_valid,
    output logic               mul_u,
    output logic               mul_su,
    output logic               mul_h,
    output logic [DATA_WD-1:0] multiplicand,
    output logic [DATA_WD-1:0] multiplier,
    input  logic [DATA_WD-1:0] product,
    input  logic               out_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               mul_valid_q, mul_valid_d;
    logic               mul_u_q, mul_u_d;
    logic               mul_su_q, mul_su_d;
    logic               mul_h_q, mul_h_d;
    logic               word_q, word_d;
    logic               ready_go_q, ready_go_d;
    logic [DATA_WD-1:0] mcand_q, mcand_d;
    logic [DATA_WD-1:0] mplier_q, mplier_d;
    logic [DATA_WD-1:0] result_q, result_d;

    function automatic logic [DATA_WD-1:0] sext32(input logic [DATA_WD-1:0] x);
        return {{(DATA_WD-32){x[31]}}, x[31:0]};
    endfunction

    always_comb begin
        state_d     = state_q;
        mul_valid_d = mul_valid_q;
        mul_u_d     = mul_u_q;
        mul_su_d    = mul_su_q;
        mul_h_d     = mul_h_q;
        word_d      = word_q;
        ready_go_d  = ready_go_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (es_valid && !flush) begin
                    state_d     = BUSY;
                    mul_valid_d = 1'b1;
                    word_d      = es_mul_w;
                    mul_u_d     = 1'b0;
                    mul_su_d    = 1'b0;
                    mul_h_d     = 1'b0;
                    // Word ops always take the low-half signed path, whatever funct3 says.
                    if (!es_mul_w) begin
                        case (es_mul_op)
                            3'b001:  mul_h_d = 1'b1;
                            3'b010:  begin mul_su_d = 1'b1; mul_h_d = 1'b1; end
                            3'b011:  begin mul_u_d  = 1'b1; mul_h_d = 1'b1; end
                            default: mul_h_d = 1'b0;
                        endcase
                    end
                    mcand_d  = es_mul_w ? sext32(es_src1) : es_src1;
                    mplier_d = es_mul_w ? sext32(es_src2) : es_src2;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d     = IDLE;
                    mul_valid_d = 1'b0;
                end else if (out_valid) begin
                    state_d     = DONE;
                    mul_valid_d = 1'b0;
                    ready_go_d  = 1'b1;
                    result_d    = word_q ? sext32(product) : product;
                end
            end
            DONE: begin
                if (flush || ms_allowin) begin
                    state_d    = IDLE;
                    ready_go_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mul_valid_d = 1'b0;
                ready_go_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mul_valid_q <= 1'b0;
            mul_u_q     <= 1'b0;
            mul_su_q    <= 1'b0;
            mul_h_q     <= 1'b0;
            word_q      <= 1'b0;
            ready_go_q  <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            mul_valid_q <= mul_valid_d;
            mul_u_q     <= mul_u_d;
            mul_su_q    <= mul_su_d;
            mul_h_q     <= mul_h_d;
            word_q      <= word_d;
            ready_go_q  <= ready_go_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            result_q    <= result_d;
        end
    end

    assign mul_valid    = mul_valid_q;
    assign mul_u        = mul_u_q;
    assign mul_su       = mul_su_q;
    assign mul_h        = mul_h_q;
    assign multiplicand = mcand_q;
    assign multiplier   = mplier_q;
    assign es_ready_go  = ready_go_q;
    assign es_result    = result_q;

endmodule

// File: tb/tb_ysyx_22041752_mul_issue.sv
// Bench for ysyx_22041752_mul_issue: behavioural iterative multiplier plus result scoreboard.
module tb_ysyx_22041752_mul_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, es_valid, es_mul_w, ms_allowin;
    logic [2:0]  es_mul_op;
    logic [63:0] es_src1, es_src2;
    logic        es_ready_go, mul_valid, mul_u, mul_su, mul_h;
    logic [63:0] es_result, multiplicand, multiplier, product;
    logic        out_valid, stray_ov;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        int          e0;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    ysyx_22041752_mul_issue #(.DATA_WD(64)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .flush        (flush),
        .es_valid     (es_valid),
        .es_mul_op    (es_mul_op),
        .es_mul_w     (es_mul_w),
        .es_src1      (es_src1),
        .es_src2      (es_src2),
        .ms_allowin   (ms_allowin),
        .es_ready_go  (es_ready_go),
        .es_result    (es_result),
        .mul_valid    (mul_valid),
        .mul_u        (mul_u),
        .mul_su       (mul_su),
        .mul_h        (mul_h),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .out_valid    (out_valid)
    );

    // Iterative multiplier: count restarts whenever mul_valid is low, answer at count 65,
    // or immediately when either operand is zero.
    int          mcnt;
    logic [127:0] ea, eb, p128;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          mcnt <= 0;
        else if (!mul_valid) mcnt <= 0;
        else                 mcnt <= mcnt + 1;
    end
    always_comb begin
        ea        = mul_u ? {64'd0, multiplicand} : {{64{multiplicand[63]}}, multiplicand};
        eb        = (mul_u || mul_su) ? {64'd0, multiplier} : {{64{multiplier[63]}}, multiplier};
        p128      = ea * eb;
        product   = mul_h ? p128[127:64] : p128[63:0];
        out_valid = stray_ov
                  | (mul_valid & ((mcnt == 65) | (multiplicand == 64'd0) | (multiplier == 64'd0)));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare on each rising edge of es_ready_go.
    logic rg_prev = 1'b0;
    always @(negedge clk) begin
        if (es_ready_go && !rg_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h with no pending multiply", es_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", es_result, e.res);
                chk("ready_cycle", 64'(ecnt - e.e0 + 1), 64'(e.cyc));
            end
        end
        rg_prev = es_ready_go;
    end

    int e0;

    // Returns at the negedge of cycle 1 (first mul_valid cycle) and checks mode/operands there.
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2,
                         input logic [63:0] res, input int cyc, input bit push,
                         input logic [2:0] mode, input logic [63:0] mc, input logic [63:0] mp);
        @(negedge clk);
        es_mul_op = op; es_mul_w = w; es_src1 = s1; es_src2 = s2; es_valid = 1'b1;
        @(negedge clk);
        es_valid = 1'b0;
        e0 = ecnt;
        if (push) sb.push_back('{res: res, cyc: cyc, e0: ecnt});
        chk("mul_valid_c1", 64'(mul_valid), 64'd1);
        chk("mode_u_su_h", 64'({mul_u, mul_su, mul_h}), 64'(mode));
        chk("multiplicand", multiplicand, mc);
        chk("multiplier", multiplier, mp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || es_ready_go) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL timeout: pending=%0d ready_go=%0b", sb.size(), es_ready_go);
        end
    endtask

    initial begin
        int vcnt, vlast;
        rst_n = 1'b0; flush = 1'b0; es_valid = 1'b0; es_mul_w = 1'b0; ms_allowin = 1'b1;
        es_mul_op = 3'd0; es_src1 = 64'd0; es_src2 = 64'd0; stray_ov = 1'b0;
        #12;
        chk("rst_outs", 64'({mul_valid, mul_u, mul_su, mul_h, es_ready_go}), 64'd0);
        chk("rst_data", multiplicand | multiplier | es_result, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Stray out_valid while idle must be ignored.
        @(negedge clk) stray_ov = 1'b1;
        @(negedge clk) stray_ov = 1'b0;
        chk("stray_ov_idle", 64'({es_ready_go, mul_valid}), 64'd0);

        // MUL 3*5 with full latency; mul_valid exactly cycles 1..66.
        issue(3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 67, 1'b1, 3'b000, 64'd3, 64'd5);
        vcnt = 1; vlast = 1;
        for (int c = 2; c <= 70; c++) begin
            @(negedge clk);
            if (mul_valid) begin vcnt++; vlast = c; end
        end
        chk("mul_valid_count", 64'(vcnt), 64'd66);
        chk("mul_valid_last", 64'(vlast), 64'd66);
        wait_idle();

        issue(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 67, 1'b1, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle();
        issue(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'd0, 67, 1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle();
        issue(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, 67, 1'b1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_idle();
        issue(3'b000, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFE, 67, 1'b1, 3'b000, 64'h0000_0000_7FFF_FFFF, 64'd2);
        wait_idle();
        // Illegal word op with high funct3 still takes the word path.
        issue(3'b011, 1'b1, 64'hAAAA_0000_8000_0000, 64'd1,
              64'hFFFF_FFFF_8000_0000, 67, 1'b1, 3'b000, 64'hFFFF_FFFF_8000_0000, 64'd1);
        wait_idle();

        // Zero-operand shortcut, held result while downstream stalls.
        ms_allowin = 1'b0;
        issue(3'b000, 1'b0, 64'd0, 64'hDEAD, 64'd0, 2, 1'b1, 3'b000, 64'd0, 64'hDEAD);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk("hold_ready", 64'(es_ready_go), 64'd1);
            chk("hold_result", es_result, 64'd0);
        end
        ms_allowin = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(es_ready_go), 64'd0);
        wait_idle();

        // Flush at cycle 10 of a BUSY multiply, then a clean 7*6.
        issue(3'b000, 1'b0, 64'd9, 64'd9, 64'd0, 0, 1'b0, 3'b000, 64'd9, 64'd9);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_mul_valid", 64'({mul_valid, es_ready_go}), 64'd0);
        issue(3'b000, 1'b0, 64'd7, 64'd6, 64'd42, 67, 1'b1, 3'b000, 64'd7, 64'd6);
        wait_idle();

        // Asynchronous reset in the middle of BUSY.
        issue(3'b011, 1'b0, 64'd5, 64'd7, 64'd0, 0, 1'b0, 3'b101, 64'd5, 64'd7);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", 64'({mul_valid, mul_u, mul_su, mul_h, es_ready_go}), 64'd0);
        chk("arst_data", multiplicand | multiplier | es_result, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        issue(3'b000, 1'b0, 64'd2, 64'd2, 64'd4, 67, 1'b1, 3'b000, 64'd2, 64'd2);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041752_mul_issue.md
# ysyx_22041752_mul_issue

Issue and result-capture controller between the EXE stage and the iterative multiplier. It accepts a RISC-V M-extension multiply (MUL/MULH/MULHSU/MULHU/MULW) from EXE and latches and conditions the operands. It drives the multiplier's mode and valid inputs until the product returns, then holds a formatted 64-bit result for the pipeline until downstream accepts it. It is the only master of the multiplier's `mul_valid`.

## Interface
Parameters:
- `DATA_WD`, 64, operand/result width (equals `RF_DATA_WD`).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  reset; asynchronous and active-low.
- `flush`  in  1  pipeline flush; kills any in-flight multiply.
- `es_valid`  in  1  EXE holds a valid multiply instruction.
- `es_mul_op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; others are illegal and treated as MUL.
- `es_mul_w`  in  1  word op (MULW); only legal with `es_mul_op`=000.
- `es_src1`, `es_src2`  in  DATA_WD  rs1, rs2 values.
- `ms_allowin`  in  1  downstream accepts this cycle.
- `es_ready_go`  out  1  result valid and held.
- `es_result`  out  DATA_WD  formatted product.
- `mul_valid`  out  1  to the multiplier.
- `mul_u`, `mul_su`, `mul_h`  out  1 each  multiplier mode.
- `multiplicand`, `multiplier`  out  DATA_WD  conditioned operands (rs1, rs2).
- `product`  in  DATA_WD  from the multiplier.
- `out_valid`  in  1  from the multiplier; may rise in the same cycle `mul_valid` rises (zero-operand shortcut, DPI build).

## Operation
- FSM states are IDLE, BUSY and DONE. All outputs are registered.
- IDLE, `es_valid` & ~`flush`:
  - Latch the operands and mode.
  - Go to BUSY.
  - `mul_valid`=1 from the next cycle.
- Mode decode:
  - MUL: u=0, su=0, h=0.
  - MULH: u=0, su=0, h=1.
  - MULHSU: u=0, su=1, h=1.
  - MULHU: u=1, su=0, h=1.
  - MULW: u=0, su=0, h=0.
- Operand conditioning:
  - MULW: `multiplicand`=sext(src1[31:0]) and `multiplier`=sext(src2[31:0]).
  - Otherwise the operands pass through unchanged.
- BUSY:
  - `mul_valid` is held at 1, with operands and mode stable.
  - On `out_valid`, capture the result and go to DONE; `mul_valid`=0 from the next cycle.
  - The result is `product`, except for MULW, where it is sext(product[31:0]).
- DONE:
  - `es_ready_go`=1 and `es_result` are held stable. `mul_valid`=0 for at least one cycle, which restarts the multiplier count.
  - On `ms_allowin`, go to IDLE and drop `es_ready_go` next cycle.
- `flush` in any state:
  - Next state is IDLE.
  - `mul_valid` and `es_ready_go` are 0 next cycle.
  - `es_result` is don't-care and need not be cleared.
  - `flush` has priority over accept, `out_valid` and `ms_allowin`.
- `es_valid` is ignored outside IDLE. The current instruction stays in EXE until it leaves, so there is no double issue.
- Illegal `es_mul_w` with a high funct3: the word path applies (sext of operands, mul_h forced 0).

## Timing
- Reset (async, active-low):
  - State is IDLE.
  - `mul_valid`, `mul_u`, `mul_su`, `mul_h`, `es_ready_go` are 0.
  - `multiplicand`, `multiplier`, `es_result` are 0.
- Reset mid-BUSY: `mul_valid` drops immediately (asynchronously) and the multiplier restarts on its own count reset.
- Cycle 0: accept in IDLE.
- Cycle 1: first `mul_valid`=1; the multiplier loads at count 0.
- Iterative multiplier: `out_valid` at count==65, i.e. cycle 66. `es_ready_go` rises at cycle 67.
- Zero operand or DPI build: `out_valid` in cycle 1, and `es_ready_go` at cycle 2.
- Throughput: one multiply per (latency + 1) cycles minimum. IDLE costs one bubble between back-to-back multiplies.
- `ms_allowin` low in DONE: hold indefinitely with no change to `es_result`.
- `out_valid` while `mul_valid`=0 (IDLE or DONE): ignore it.

## Test plan
- MUL 3 × 5 → `es_result`=15. `es_ready_go` rises at cycle 67. `mul_valid` is high for exactly cycles 1–66.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × same → 0xFFFF_FFFF_FFFF_FFFE; MULH −1 × −1 → 0; MULHSU −1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW src1=0x1234_5678_7FFF_FFFF, src2=2:
  - `multiplicand`=0x0000_0000_7FFF_FFFF.
  - `es_result`=0xFFFF_FFFF_FFFF_FFFE.
- MUL 0 × 0xDEAD → `es_result`=0 with `es_ready_go` at cycle 2. Then hold `ms_allowin`=0 for 5 cycles → result stable; release → IDLE next cycle.
- Flush at BUSY cycle 10:
  - `mul_valid`=0 at cycle 11 and state IDLE.
  - A new MUL 7 × 6 issued at cycle 12 → 42 after the full 66-cycle latency, with no stale product.
- Assert `reset` (low) mid-BUSY → all outputs 0 immediately. Release it; a subsequent MUL 2 × 2 → 4 with correct latency.
